// File: rtl/alu_test_sequencer.sv
// rtl/alu_test_sequencer.sv - ALU test-vector sequencer: loads operands, executes, checks and tallies results
// Optional halt-on-mismatch behaviour is enabled by defining SEQ_HALT_ON_FAIL_EN.
module alu_test_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        vec_valid,
    output logic        vec_ready,
    input  logic [15:0] vec_a,
    input  logic [15:0] vec_b,
    input  logic [7:0]  vec_op,
    input  logic        vec_cin,
    input  logic [15:0] vec_expect,
    output logic [15:0] imm,
    output logic        immen,
    output logic [4:0]  regen,
    output logic [4:0]  bufa,
    output logic [4:0]  bufb,
    output logic [7:0]  aluop,
    output logic        cin,
    output logic [5:0]  reg_rd,
    input  logic [15:0] result,
    output logic [7:0]  pass_cnt,
    output logic [7:0]  fail_cnt,
    output logic [7:0]  vec_idx,
    output logic [7:0]  last_fail,
    output logic        halted
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD_A = 3'd1;
    localparam logic [2:0] S_LOAD_B = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
`ifdef SEQ_HALT_ON_FAIL_EN
    localparam logic [2:0] S_HALT   = 3'd5;
`endif

    // Register-file slots used for operand A, operand B and the ALU result.
    localparam logic [3:0] REG_A   = 4'd1;
    localparam logic [3:0] REG_B   = 4'd2;
    localparam logic [3:0] REG_RES = 4'd3;

    logic [2:0]  state;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [7:0]  op_q;
    logic        cin_q;
    logic [15:0] exp_q;
    logic        match;
    logic        transfer;

    assign match    = (result == exp_q);
    assign transfer = vec_valid && (state == S_IDLE);
    assign reg_rd   = {2'b00, REG_RES};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            a_q       <= 16'd0;
            b_q       <= 16'd0;
            op_q      <= 8'd0;
            cin_q     <= 1'b0;
            exp_q     <= 16'd0;
            pass_cnt  <= 8'd0;
            fail_cnt  <= 8'd0;
            vec_idx   <= 8'd0;
            last_fail <= 8'd0;
        end else if (clear) begin
            state     <= S_IDLE;
            pass_cnt  <= 8'd0;
            fail_cnt  <= 8'd0;
            vec_idx   <= 8'd0;
            last_fail <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (transfer) begin
                        a_q   <= vec_a;
                        b_q   <= vec_b;
                        op_q  <= vec_op;
                        cin_q <= vec_cin;
                        exp_q <= vec_expect;
                        state <= S_LOAD_A;
                    end
                end
                S_LOAD_A: state <= S_LOAD_B;
                S_LOAD_B: state <= S_EXEC;
                S_EXEC:   state <= S_CHECK;
                S_CHECK: begin
                    vec_idx <= vec_idx + 8'd1;
                    if (match) begin
                        if (pass_cnt != 8'hFF) pass_cnt <= pass_cnt + 8'd1;
                        state <= S_IDLE;
                    end else begin
                        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
                        last_fail <= vec_idx;
`ifdef SEQ_HALT_ON_FAIL_EN
                        state <= S_HALT;
`else
                        state <= S_IDLE;
`endif
                    end
                end
`ifdef SEQ_HALT_ON_FAIL_EN
                S_HALT: state <= S_HALT;
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

    // Outputs depend only on the state and latched vector, never on live inputs.
    always_comb begin
        vec_ready = 1'b0;
        imm       = 16'd0;
        immen     = 1'b0;
        regen     = 5'd0;
        bufa      = 5'd0;
        bufb      = 5'd0;
        aluop     = 8'd0;
        cin       = 1'b0;
        case (state)
            S_IDLE: vec_ready = 1'b1;
            S_LOAD_A: begin
                imm   = a_q;
                immen = 1'b1;
                regen = {1'b1, REG_A};
            end
            S_LOAD_B: begin
                imm   = b_q;
                immen = 1'b1;
                regen = {1'b1, REG_B};
            end
            S_EXEC: begin
                bufa  = {1'b1, REG_A};
                bufb  = {1'b1, REG_B};
                aluop = op_q;
                cin   = cin_q;
                regen = {1'b1, REG_RES};
            end
            default: ;
        endcase
    end

`ifdef SEQ_HALT_ON_FAIL_EN
    assign halted = (state == S_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
